// File: rtl/regfile_wb_arbiter.sv
// Writeback scheduler: per-source one-entry buffers, same-rd age ordering, round-robin dual-port grant.
// Accept at edge N, write earliest at N+1; a full, ungranted buffer holds src_ready low. WB_ARB_STATS_EN adds stall_cnt.
module regfile_wb_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int XLEN    = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_SRC-1:0]      src_valid,
  output logic [NUM_SRC-1:0]      src_ready,
  input  logic [5*NUM_SRC-1:0]    src_rd,
  input  logic [XLEN*NUM_SRC-1:0] src_data,
  output logic                    we1,
  output logic [4:0]              rd1,
  output logic [XLEN-1:0]         wdata1,
  output logic                    we2,
  output logic [4:0]              rd2,
  output logic [XLEN-1:0]         wdata2,
  output logic [31:0]             pend_mask,
  output logic [31:0]             stall_cnt
);
  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] buf_v;
  logic [4:0]         buf_rd   [NUM_SRC];
  logic [XLEN-1:0]    buf_data [NUM_SRC];
  logic [NUM_SRC-1:0] older     [NUM_SRC];  // older[j][i]: j accepted strictly before i
  logic [NUM_SRC-1:0] older_nxt [NUM_SRC];
  logic [PW-1:0]      rr_ptr, rr_nxt, idx1, idx2, last;
  logic [NUM_SRC-1:0] elig, gnt, acc, new_v, keep;
  logic               hit1, hit2;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      elig[i] = buf_v[i];
      for (int j = 0; j < NUM_SRC; j++) begin
        if (j != i && buf_v[j] && older[j][i] && buf_rd[j] == buf_rd[i])
          elig[i] = 1'b0;
      end
    end
  end

  // Two passes rotate the scan to start at rr_ptr without a variable index.
  always_comb begin
    hit1   = 1'b0;
    hit2   = 1'b0;
    idx1   = '0;
    idx2   = '0;
    rd1    = '0;
    rd2    = '0;
    wdata1 = '0;
    wdata2 = '0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (((pass == 0) == (i >= int'(rr_ptr))) && elig[i]) begin
          if (!hit1) begin
            hit1   = 1'b1;
            idx1   = PW'(i);
            rd1    = buf_rd[i];
            wdata1 = buf_data[i];
          end else if (!hit2) begin
            hit2   = 1'b1;
            idx2   = PW'(i);
            rd2    = buf_rd[i];
            wdata2 = buf_data[i];
          end
        end
      end
    end
    we1 = hit1;
    we2 = hit2;
    last   = hit2 ? idx2 : idx1;
    rr_nxt = (int'(last) == NUM_SRC - 1) ? '0 : last + 1'b1;
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      gnt[i]       = (hit1 && idx1 == PW'(i)) || (hit2 && idx2 == PW'(i));
      src_ready[i] = ~buf_v[i] | gnt[i];
      acc[i]       = src_valid[i] & src_ready[i];
      new_v[i]     = acc[i] & (|src_rd[5*i +: 5]);
      keep[i]      = buf_v[i] & ~gnt[i];
    end
  end

  // A new entry is younger than every survivor and than lower-index simultaneous accepts.
  always_comb begin
    for (int j = 0; j < NUM_SRC; j++) begin
      older_nxt[j] = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (i == j)
          older_nxt[j][i] = 1'b0;
        else if (new_v[i])
          older_nxt[j][i] = keep[j] | (new_v[j] && j < i);
        else if (new_v[j])
          older_nxt[j][i] = 1'b0;
        else
          older_nxt[j][i] = older[j][i] & keep[i] & keep[j];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_v  <= '0;
      rr_ptr <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        buf_rd[i]   <= '0;
        buf_data[i] <= '0;
        older[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (acc[i]) begin
          buf_v[i]    <= new_v[i];
          buf_rd[i]   <= src_rd[5*i +: 5];
          buf_data[i] <= src_data[XLEN*i +: XLEN];
        end else if (gnt[i]) begin
          buf_v[i] <= 1'b0;
        end
        older[i] <= older_nxt[i];
      end
      if (hit1)
        rr_ptr <= rr_nxt;
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (buf_v[i])
        pend_mask[buf_rd[i]] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

`ifdef WB_ARB_STATS_EN
  logic stall;
  assign stall = |(buf_v & ~gnt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stall_cnt <= '0;
    else if (stall && stall_cnt != '1)
      stall_cnt <= stall_cnt + 32'd1;
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a regfile model fed from the write ports.
module tb_regfile_wb_arbiter;
  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   src_valid;
  logic [3:0]   src_ready;
  logic [19:0]  src_rd;
  logic [127:0] src_data;
  logic         we1, we2;
  logic [4:0]   rd1, rd2;
  logic [31:0]  wdata1, wdata2, pend_mask, stall_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] regs [32];
  int wcnt [32] = '{default: 0};
  int nwrites = 0, dual = 0, collide = 0, zero_wr = 0;
  bit win = 1'b0;
  logic [31:0] s0, s1;
  int wr0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NUM_SRC(4), .XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .src_valid(src_valid), .src_ready(src_ready), .src_rd(src_rd), .src_data(src_data),
    .we1(we1), .rd1(rd1), .wdata1(wdata1),
    .we2(we2), .rd2(rd2), .wdata2(wdata2),
    .pend_mask(pend_mask), .stall_cnt(stall_cnt)
  );

  always @(negedge clk) begin
    if (reset_n) begin
      if (we1) begin
        regs[rd1] = wdata1;
        nwrites++;
        if (win) wcnt[rd1]++;
      end
      if (we2) begin
        regs[rd2] = wdata2;
        nwrites++;
        if (win) wcnt[rd2]++;
      end
      if (we1 && we2 && rd1 == rd2) collide++;
      if ((we1 && rd1 == 5'd0) || (we2 && rd2 == 5'd0)) zero_wr++;
      if (win && we1 && we2) dual++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_src(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
    src_valid[i]       = v;
    src_rd[i*5 +: 5]   = rd;
    src_data[i*32 +: 32] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    src_valid = '0;
    src_rd = '0;
    src_data = '0;
    #2;
    check("rst_we1", we1, 0);
    check("rst_we2", we2, 0);
    check("rst_pend", pend_mask, 0);
    #10 reset_n = 1'b1;
    tick();
    check("rst_ready", src_ready, 4'hF);

    // three sources from rr_ptr=0
    set_src(0, 1, 5'd3, 32'hA0);
    set_src(1, 1, 5'd4, 32'hA1);
    set_src(2, 1, 5'd6, 32'hA2);
    tick();
    src_valid = '0;
    check("t3_rd1", {we1, rd1, wdata1}, {1'b1, 5'd3, 32'hA0});
    check("t3_rd2", {we2, rd2, wdata2}, {1'b1, 5'd4, 32'hA1});
    check("t3_pend", pend_mask, 32'h58);
    check("t3_ready", src_ready, 4'b1011);
    tick();
    check("t3_c2_p1", {we1, rd1, wdata1}, {1'b1, 5'd6, 32'hA2});
    check("t3_c2_we2", we2, 0);
    check("t3_c2_pend", pend_mask, 32'h40);
    tick();
    check("t3_idle", {we1, we2}, 2'b00);
    check("t3_pend0", pend_mask, 0);

    // rr_ptr now 3: source 3 scanned before source 0
    set_src(0, 1, 5'd8, 32'hB0);
    set_src(3, 1, 5'd9, 32'hB3);
    tick();
    src_valid = '0;
    check("rr_p1", {we1, rd1, wdata1}, {1'b1, 5'd9, 32'hB3});
    check("rr_p2", {we2, rd2, wdata2}, {1'b1, 5'd8, 32'hB0});
    tick();

    // single write, visible for exactly one cycle
    set_src(0, 1, 5'd5, 32'hDEADBEEF);
    tick();
    src_valid = '0;
    check("one_p1", {we1, rd1, wdata1}, {1'b1, 5'd5, 32'hDEADBEEF});
    check("one_we2", we2, 0);
    check("one_pend", pend_mask, 32'h20);
    tick();
    check("one_done", we1, 0);
    check("one_pend0", pend_mask, 0);

    // rr_ptr=1: src0 stalls, src1 refills with src0's rd -> src0 older despite higher scan order
    set_src(0, 1, 5'd3, 32'h10);
    set_src(1, 1, 5'd4, 32'h11);
    set_src(2, 1, 5'd6, 32'h12);
    tick();
    check("age_c1_p1", {we1, rd1, wdata1}, {1'b1, 5'd4, 32'h11});
    check("age_c1_p2", {we2, rd2, wdata2}, {1'b1, 5'd6, 32'h12});
    check("age_stall_ready", src_ready, 4'b1110);
    src_valid = '0;
    set_src(1, 1, 5'd3, 32'h21);
    tick();
    src_valid = '0;
    check("age_c2_p1", {we1, rd1, wdata1}, {1'b1, 5'd3, 32'h10});
    check("age_c2_we2", we2, 0);
    check("age_c2_pend", pend_mask, 32'h08);
    tick();
    check("age_c3_p1", {we1, rd1, wdata1}, {1'b1, 5'd3, 32'h21});
    check("age_c3_we2", we2, 0);
    tick();
    check("age_reg3", regs[3], 32'h21);

    // src1 rd7 one cycle ahead of src0 rd7
    set_src(1, 1, 5'd7, 32'h1);
    tick();
    src_valid = '0;
    check("ord_c1", {we1, rd1, wdata1}, {1'b1, 5'd7, 32'h1});
    set_src(0, 1, 5'd7, 32'h2);
    check("ord_ready0", src_ready[0], 1);
    tick();
    src_valid = '0;
    check("ord_c2", {we1, rd1, wdata1}, {1'b1, 5'd7, 32'h2});
    check("ord_c2_we2", we2, 0);
    tick();
    check("ord_reg7", regs[7], 32'h2);

    // simultaneous same-rd accepts, rr_ptr=1: lower index still wins
    set_src(0, 1, 5'd12, 32'hA);
    set_src(1, 1, 5'd12, 32'hB);
    tick();
    src_valid = '0;
    check("sim_c1", {we1, rd1, wdata1}, {1'b1, 5'd12, 32'hA});
    check("sim_c1_we2", we2, 0);
    tick();
    check("sim_c2", {we1, rd1, wdata1}, {1'b1, 5'd12, 32'hB});
    tick();
    check("sim_reg12", regs[12], 32'hB);

    // rd=0 is consumed and dropped
    set_src(3, 1, 5'd0, 32'hFF);
    check("rd0_ready", src_ready[3], 1);
    tick();
    src_valid = '0;
    check("rd0_we", {we1, we2}, 2'b00);
    check("rd0_pend", pend_mask, 0);
    tick();
    check("rd0_we_later", {we1, we2}, 2'b00);

    // all four sources saturated for 100 cycles
    for (int i = 0; i < 4; i++) set_src(i, 1, 5'(16 + i), 32'(i + 100));
    tick();
    win = 1'b1;
    s0 = stall_cnt;
    repeat (100) tick();
    win = 1'b0;
    s1 = stall_cnt;
    src_valid = '0;
    for (int i = 0; i < 4; i++) check($sformatf("fair_src%0d", i), wcnt[16 + i], 50);
    check("fair_dual", dual, 100);
`ifdef WB_ARB_STATS_EN
    check("stall_delta", s1 - s0, 100);
`else
    check("stall_zero", s1, 0);
`endif
    repeat (3) tick();

    // asynchronous reset with three buffers full
    set_src(0, 1, 5'd3, 32'hC0);
    set_src(1, 1, 5'd4, 32'hC1);
    set_src(2, 1, 5'd6, 32'hC2);
    tick();
    src_valid = '0;
    check("mid_pend_pre", pend_mask, 32'h58);
    #2 reset_n = 1'b0;
    #1;
    check("mid_we", {we1, we2}, 2'b00);
    check("mid_pend", pend_mask, 0);
    wr0 = nwrites;
    tick();
    #2 reset_n = 1'b1;
    repeat (3) tick();
    check("mid_no_writes", nwrites, wr0);
    set_src(2, 1, 5'd10, 32'h5);
    tick();
    src_valid = '0;
    check("post_rst_p1", {we1, rd1, wdata1}, {1'b1, 5'd10, 32'h5});
    tick();

    check("no_collide", collide, 0);
    check("no_zero_wr", zero_wr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
